// File: rtl/ref_window_loader_pkg.sv
// Shared constants and types for the reference-window loader.
package win_pkg;

  localparam int PIX_W     = 8;            // bits per luma sample
  localparam int WIN       = 15;           // window width/height (8x8 block + 7 taps)
  localparam int ROW_W     = WIN * PIX_W;  // one packed window row
  localparam int ROW_IDX_W = 4;            // row/column index width

  typedef logic [ROW_IDX_W-1:0] idx_t;
  typedef logic [ROW_W-1:0]     row_t;

  localparam idx_t LAST_IDX = idx_t'(WIN - 1);

  // Loader is either hunting for a start-of-frame or filling a window.
  typedef enum logic {
    LD_HUNT,
    LD_FILL
  } load_state_e;

endpackage

// File: rtl/ref_window_loader_if.sv
// Pixel-stream and window-read bus between the loader and its neighbours.
interface ref_window_loader_if import win_pkg::*;;

  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             pix_sof;
  logic             pix_ready;
  idx_t             rd_row;
  row_t             out_row;
  logic             win_valid;
  logic             win_done;
  logic             resync_err;

  modport master (
    output pix_in, pix_valid, pix_sof, rd_row, win_done,
    input  pix_ready, out_row, win_valid, resync_err
  );

  modport slave (
    input  pix_in, pix_valid, pix_sof, rd_row, win_done,
    output pix_ready, out_row, win_valid, resync_err
  );

endinterface

// File: rtl/ref_window_loader_window_bank.sv
// One WIN x WIN pixel bank: single pixel write port, zero-latency row read.
module window_bank import win_pkg::*; (
  input  logic             clk,
  input  logic             we_i,
  input  idx_t             wr_row_i,
  input  idx_t             wr_col_i,
  input  logic [PIX_W-1:0] pix_i,
  input  idx_t             rd_row_i,
  output row_t             rd_data_o
);

  row_t rows_q [WIN];

  // Pixel write; bank contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we_i && (wr_row_i <= LAST_IDX)) begin
      rows_q[wr_row_i][wr_col_i*PIX_W +: PIX_W] <= pix_i;
    end
  end

  // Combinational row read, zero for indices past the last row.
  always_comb begin
    rd_data_o = '0;
    if (rd_row_i <= LAST_IDX) begin
      rd_data_o = rows_q[rd_row_i];
    end
  end

endmodule

// File: rtl/ref_window_loader.sv
// Turns a raster pixel stream into ping-pong buffered 15x15 windows that
// the interpolator reads row by row with zero latency.
module ref_window_loader import win_pkg::*; (
  input  logic                clk,
  input  logic                rst,
  ref_window_loader_if.slave  bus
);

  logic [1:0]  full_q, full_d;
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  idx_t        col_q, col_d;
  idx_t        row_q, row_d;
  load_state_e st_q, st_d;
  logic        resync_q, resync_d;

  logic        accept;
  logic        we;
  idx_t        wr_row, wr_col;
  row_t        rd0, rd1;
  logic        win_valid;

  // Register state; synchronous active-low reset discards any partial window.
  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      st_q      <= LD_HUNT;
      resync_q  <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      col_q     <= col_d;
      row_q     <= row_d;
      st_q      <= st_d;
      resync_q  <= resync_d;
    end
  end

  // Next-state: stream acceptance, raster counters, bank hand-off and release.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    col_d     = col_q;
    row_d     = row_q;
    st_d      = st_q;
    resync_d  = 1'b0;
    we        = 1'b0;
    wr_row    = row_q;
    wr_col    = col_q;
    accept    = bus.pix_valid & ~full_q[wr_bank_q];

    if (accept) begin
      if (bus.pix_sof) begin
        we       = 1'b1;
        wr_row   = '0;
        wr_col   = '0;
        col_d    = idx_t'(1);
        row_d    = '0;
        st_d     = LD_FILL;
        resync_d = (st_q == LD_FILL) && ((row_q != '0) || (col_q != '0));
      end else if (st_q == LD_FILL) begin
        we = 1'b1;
        if (col_q == LAST_IDX) begin
          col_d = '0;
          if (row_q == LAST_IDX) begin
            row_d               = '0;
            st_d                = LD_HUNT;
            full_d[wr_bank_q]   = 1'b1;
            wr_bank_d           = ~wr_bank_q;
          end else begin
            row_d = row_q + idx_t'(1);
          end
        end else begin
          col_d = col_q + idx_t'(1);
        end
      end
    end

    // Release never collides with a fill: fill needs an empty bank, release a full one.
    if (bus.win_done && full_q[rd_bank_q]) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  window_bank u_bank0 (
    .clk       (clk),
    .we_i      (we & ~wr_bank_q),
    .wr_row_i  (wr_row),
    .wr_col_i  (wr_col),
    .pix_i     (bus.pix_in),
    .rd_row_i  (bus.rd_row),
    .rd_data_o (rd0)
  );

  window_bank u_bank1 (
    .clk       (clk),
    .we_i      (we & wr_bank_q),
    .wr_row_i  (wr_row),
    .wr_col_i  (wr_col),
    .pix_i     (bus.pix_in),
    .rd_row_i  (bus.rd_row),
    .rd_data_o (rd1)
  );

  assign win_valid      = full_q[rd_bank_q];
  assign bus.win_valid  = win_valid;
  assign bus.pix_ready  = ~full_q[wr_bank_q];
  assign bus.resync_err = resync_q;
  assign bus.out_row    = win_valid ? (rd_bank_q ? rd1 : rd0) : '0;

endmodule

// File: tb/tb_ref_window_loader.sv
// Scoreboard bench for ref_window_loader: a queue-based window model is
// updated from the stimulus each edge; a monitor compares DUT outputs.
module tb_ref_window_loader;
  import win_pkg::*;

  localparam int NPIX = WIN * WIN;
  typedef logic [NPIX*PIX_W-1:0] win_t;

  logic clk = 1'b0;
  logic rst;

  ref_window_loader_if bus ();

  ref_window_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;
  bit abort  = 1'b0;

  // Reference model state: completed windows awaiting release, window in progress.
  win_t             exp_win_q [$];
  logic [PIX_W-1:0] cur_q     [$];
  bit               m_synced   = 1'b0;
  bit               exp_resync = 1'b0;

  task automatic chk(input string name, input row_t act, input row_t exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: windows are whole 225-pixel units queued in completion order.
  initial begin
    bit   rdy;
    bit   had_win;
    win_t w;
    forever begin
      @(posedge clk);
      if (rst !== 1'b1) begin
        exp_win_q.delete();
        cur_q.delete();
        m_synced   = 1'b0;
        exp_resync = 1'b0;
      end else begin
        exp_resync = 1'b0;
        rdy        = exp_win_q.size() < 2;
        had_win    = exp_win_q.size() > 0;
        if (bus.pix_valid === 1'b1 && rdy) begin
          if (bus.pix_sof === 1'b1) begin
            if (m_synced) exp_resync = 1'b1;
            cur_q.delete();
            cur_q.push_back(bus.pix_in);
            m_synced = 1'b1;
          end else if (m_synced) begin
            cur_q.push_back(bus.pix_in);
            if (cur_q.size() == NPIX) begin
              for (int unsigned k = 0; k < NPIX; k++) w[k*PIX_W +: PIX_W] = cur_q[k];
              exp_win_q.push_back(w);
              cur_q.delete();
              m_synced = 1'b0;
            end
          end
        end
        if (bus.win_done === 1'b1 && had_win) void'(exp_win_q.pop_front());
      end
    end
  end

  // Monitor: compare DUT outputs against the model just after every edge.
  initial begin
    row_t exp_row;
    win_t w2;
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        exp_row = '0;
        if (exp_win_q.size() > 0 && bus.rd_row <= LAST_IDX) begin
          w2      = exp_win_q[0];
          exp_row = w2[int'(bus.rd_row)*ROW_W +: ROW_W];
        end
        chk("win_valid",  row_t'(bus.win_valid),  row_t'(exp_win_q.size() > 0));
        chk("pix_ready",  row_t'(bus.pix_ready),  row_t'(exp_win_q.size() < 2));
        chk("resync_err", row_t'(bus.resync_err), row_t'(exp_resync));
        chk("out_row",    bus.out_row,            exp_row);
      end
    end
  end

  // Present one pixel; waits (bounded) for pix_ready. Called and returns at negedge.
  task automatic send(input logic [PIX_W-1:0] p, input logic s);
    int unsigned n;
    n = 0;
    if (abort) return;
    bus.pix_in    = p;
    bus.pix_sof   = s;
    bus.pix_valid = 1'b1;
    while (bus.pix_ready !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        checks++;
        fails++;
        $display("FAIL send_timeout: pix_ready actual=%b required=1", bus.pix_ready);
        abort = 1'b1;
        bus.pix_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
  endtask

  // Raster pixels [start, start+count): pattern {row,col}+base or random data.
  task automatic send_pixels(input logic [PIX_W-1:0] base, input int unsigned start,
                             input int unsigned count, input bit rnd, input bit gaps);
    logic [PIX_W-1:0] p;
    for (int unsigned k = start; k < start + count; k++) begin
      p = rnd ? PIX_W'($urandom) : ({4'(k / WIN), 4'(k % WIN)} + base);
      send(p, k == 0);
      if (gaps && ($urandom_range(0, 7) == 0)) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  // Wait (bounded) for a window, sweep every row index, then release it.
  task automatic consume();
    int unsigned n;
    n = 0;
    if (abort) return;
    while (bus.win_valid !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 4000) begin
        checks++;
        fails++;
        $display("FAIL consume_timeout: win_valid actual=%b required=1", bus.win_valid);
        abort = 1'b1;
        return;
      end
    end
    for (int unsigned r = 0; r < 16; r++) begin
      bus.rd_row = 4'(r);
      @(negedge clk);
    end
    bus.rd_row   = '0;
    bus.win_done = 1'b1;
    @(negedge clk);
    bus.win_done = 1'b0;
  endtask

  initial begin
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.rd_row    = '0;
    bus.win_done  = 1'b0;
    rst           = 1'b0;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    // Single patterned window.
    send_pixels(8'h00, 0, NPIX, 1'b0, 1'b0);
    bus.rd_row = 4'd0;
    #1 chk("row0_pattern", bus.out_row, 120'h0E0D0C0B0A09080706050403020100);
    bus.rd_row = 4'd14;
    #1 chk("row14_lsb", row_t'(bus.out_row[7:0]), row_t'(8'hE0));
    chk("row14_msb", row_t'(bus.out_row[ROW_W-1 -: 8]), row_t'(8'hEE));
    bus.rd_row = 4'd15;
    #1 chk("row15_zero", bus.out_row, '0);
    @(negedge clk);
    consume();

    // Two windows back-to-back, no release: stream stalls, window 1 stays visible.
    send_pixels(8'h00, 0, NPIX, 1'b0, 1'b0);
    send_pixels(8'h80, 0, NPIX, 1'b0, 1'b0);
    bus.rd_row = 4'd0;
    #1 chk("both_full_ready", row_t'(bus.pix_ready), row_t'(1'b0));
    chk("both_full_w1_lsb", row_t'(bus.out_row[7:0]), row_t'(8'h00));
    @(negedge clk);
    bus.win_done = 1'b1;
    @(posedge clk);
    #1 chk("after_done_w2_lsb", row_t'(bus.out_row[7:0]), row_t'(8'h80));
    chk("after_done_ready", row_t'(bus.pix_ready), row_t'(1'b1));
    @(negedge clk);
    bus.win_done = 1'b0;
    consume();

    // Resync after 40 pixels; finished window starts at the resync pixel.
    send_pixels(8'h00, 0, 40, 1'b0, 1'b0);
    send_pixels(8'h40, 0, NPIX, 1'b0, 1'b0);
    bus.rd_row = 4'd0;
    #1 chk("resync_r0c0", row_t'(bus.out_row[7:0]), row_t'(8'h40));
    @(negedge clk);
    consume();

    // Fresh reset, 10 unaligned pixels dropped, then a random window.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int unsigned i = 0; i < 10; i++) send(PIX_W'($urandom), 1'b0);
    send_pixels(8'h00, 0, NPIX, 1'b1, 1'b0);
    consume();

    // Release with nothing valid is ignored.
    bus.win_done = 1'b1;
    @(negedge clk);
    bus.win_done = 1'b0;

    // Last pixel of window B and release of window A on the same edge.
    send_pixels(8'h20, 0, NPIX, 1'b0, 1'b0);
    send_pixels(8'hA0, 0, NPIX - 1, 1'b0, 1'b0);
    bus.win_done = 1'b1;
    send_pixels(8'hA0, NPIX - 1, 1, 1'b0, 1'b0);
    bus.win_done = 1'b0;
    bus.rd_row   = 4'd0;
    #1 chk("same_cycle_valid", row_t'(bus.win_valid), row_t'(1'b1));
    chk("same_cycle_b_lsb", row_t'(bus.out_row[7:0]), row_t'(8'hA0));
    @(negedge clk);
    consume();

    // Reset at pixel 100 with another window already full.
    send_pixels(8'h30, 0, NPIX, 1'b0, 1'b0);
    send_pixels(8'h50, 0, 100, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("rst_win_valid", row_t'(bus.win_valid), row_t'(1'b0));
    chk("rst_pix_ready", row_t'(bus.pix_ready), row_t'(1'b1));
    chk("rst_out_row", bus.out_row, '0);
    @(negedge clk);
    rst = 1'b1;
    send_pixels(8'h00, 0, NPIX, 1'b1, 1'b0);
    consume();

    // Random traffic: gaps, stray pixels, an early resync, randomly delayed release.
    fork
      begin
        for (int unsigned w = 0; w < 4; w++) begin
          if (w == 1) send_pixels(8'h00, 0, $urandom_range(2, 120), 1'b1, 1'b1);
          if (w == 2) for (int unsigned i = 0; i < 3; i++) send(PIX_W'($urandom), 1'b0);
          send_pixels(8'h00, 0, NPIX, 1'b1, 1'b1);
        end
      end
      begin
        for (int unsigned w = 0; w < 4; w++) begin
          repeat ($urandom_range(0, 300)) @(negedge clk);
          consume();
        end
      end
    join

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/ref_window_loader.md
Name: ref_window_loader

Overview:
- Upstream feeder for subpixel_interpolation: turns a raster pixel stream from reference-frame memory into 15x15 integer-pixel windows.
- Presents rows by index with zero latency, so the interpolator's next_row to in_row path works unchanged.
- Ping-pong double buffer: window N+1 loads while the interpolator consumes window N.

Parameters:
PIX_W, 8, bits per luma sample
WIN, 15, window width and height in pixels (8x8 block + 7 filter taps)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-low reset
pix_in  in  PIX_W  stream pixel, raster order (row 0 col 0 first)
pix_valid  in  1  pix_in valid
pix_sof  in  1  marks first pixel of a window; qualified by pix_valid
pix_ready  out  1  loader accepts pix_in this cycle
rd_row  in  4  row index requested by interpolator (its next_row)
out_row  out  WIN*PIX_W  selected row; column c at bits [c*PIX_W+PIX_W-1 : c*PIX_W]
win_valid  out  1  a complete window is readable
win_done  in  1  one-cycle pulse from consumer: current window released
resync_err  out  1  one-cycle pulse: sof arrived mid-window

Behaviour:
- State:
  - 2 banks (bank0, bank1) of WIN rows x WIN*PIX_W bits.
  - wr_bank and rd_bank pointers (1 bit each); full[1:0].
  - col and row counters (0..WIN-1); sync bit.
- Reset (rst==0 at edge): full=0, wr_bank=rd_bank=0, col=row=0, sync=0, resync_err=0.
  - Outputs then: pix_ready=1, win_valid=0, out_row=0.
  - Bank contents are not reset. A partially loaded window is discarded.
- pix_ready = !full[wr_bank] (combinational).
- Accept = pix_valid & pix_ready.
- Accept with pix_sof=1:
  - Write pix_in to wr_bank[0][col 0]; col=1, row=0, sync=1.
  - If (row,col) was not (0,0) and sync was 1, pulse resync_err for one cycle. The partial data is overwritten by the new window.
- Accept with pix_sof=0 and sync=0: pixel is consumed (ready high) and dropped. Counters hold.
- Accept with pix_sof=0 and sync=1: write to wr_bank[row][col], then col++. At col==WIN-1, col=0 and row++.
- Accept of pixel (WIN-1, WIN-1), i.e. the 225th pixel:
  - full[wr_bank]<=1; wr_bank toggles.
  - col=row=0, sync=0. Each window needs its own sof.
- A window is never visible partially. win_valid rises the cycle after its last pixel is accepted.
- win_valid = full[rd_bank].
- out_row:
  - Equals rd_bank row rd_row, combinational from rd_row (0 cycles) while win_valid=1.
  - 0 when win_valid=0 or rd_row>WIN-1.
- win_done while win_valid=1: full[rd_bank]<=0; rd_bank toggles.
- win_done while win_valid=0: ignored, no state change.
- Same-cycle last-pixel accept and win_done: both take effect. They always target different banks.
- Both banks full: pix_ready=0, stream stalls. pix_ready returns to 1 the cycle after win_done.
- Throughput: one pixel per cycle. A window loads in 225 accepted cycles.

Decomposition:
- Package win_pkg holds:
  - PIX_W, WIN;
  - ROW_W = WIN*PIX_W;
  - ROW_IDX_W = 4;
  - LAST_IDX = WIN-1.
- Sub-module window_bank, instantiated twice. It holds the WIN row registers, has a write port (we, row, col, pixel) and a combinational read port (rd_row to row data).
- Top level owns counters, sync, full flags, bank pointers and the output mux.

Test Plan:
- Reset, then one window with pixel = {row[3:0],col[3:0]} (e.g. r3c2=0x32), sof on first, no stalls:
  - win_valid rises exactly 1 cycle after the 225th accept.
  - rd_row=0 gives out_row=0x0E0D...0100.
  - rd_row=14 gives LSB byte 0xE0 and MSB byte 0xEE.
  - rd_row=15 gives 0.
- Two windows back-to-back (second pixels +0x80), no win_done:
  - After the second window, pix_ready=0 and out_row still shows window 1.
  - win_done once: next cycle out_row(row 0) LSB=0x80 and pix_ready=1.
- sof reasserted after 40 pixels of a window:
  - resync_err pulses once.
  - The finished window holds only post-resync data: row 0 col 0 = the resync pixel.
- After reset, 10 pixels without sof, then a full window:
  - The 10 pixels are dropped (pix_ready=1 throughout).
  - Window content matches the sof-aligned data exactly.
- win_done pulsed with win_valid=0: no change to pointers or flags.
  - Also drive the 225th pixel and win_done in the same cycle with one bank full: both banks end in the correct state, win_valid=1 with the new window.
- rst=0 asserted mid-window at pixel 100:
  - Next cycle: win_valid=0, pix_ready=1, out_row=0.
  - A subsequent full window loads correctly.
